// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: shared encodings for the byte-serial memory arbiter.
// Holds the access-type and state encodings, the grant owner encoding,
// the latched-transaction payload, the IO region constant and UART addresses.
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        ACC_BYTE = 2'b00,
        ACC_HALF = 2'b01,
        ACC_WORD = 2'b10
    } accessType;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        IREAD  = 2'b01,
        DREAD  = 2'b10,
        DWRITE = 2'b11
    } arbState;

    typedef enum logic {
        GRANT_INSTR = 1'b0,
        GRANT_DATA  = 1'b1
    } grantSel;

    // Latched request: base byte address and store data.
    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] wrData;
    } txnT;

    // Address bits [17:16] == IO_REGION select memory-mapped IO.
    localparam logic [1:0]  IO_REGION      = 2'b11;
    localparam logic [31:0] IO_UART_DATA   = 32'h0003_0000;
    localparam logic [31:0] IO_UART_STATUS = 32'h0003_0004;

    // Bytes moved for a data access; the reserved encoding behaves as a word.
    function automatic logic [2:0] byteCount(input logic [1:0] accType);
        case (accType)
            ACC_BYTE: byteCount = 3'd1;
            ACC_HALF: byteCount = 3'd2;
            default:  byteCount = 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/mem_byte_collector.sv
// mem_byte_collector: BLOCK_SIZE-byte assemble register for read data.
// Ports: clockIn/resetIn (async active-low), enable (global freeze when low),
// clear (zero the line), writeEn/writeIdx/byteIn (store one byte),
// lineNext (line including the byte being written this cycle).
module mem_byte_collector #(
    parameter int unsigned BLOCK_WIDTH = 4,
    parameter int unsigned BLOCK_SIZE  = 16
) (
    input  logic                      clockIn,
    input  logic                      resetIn,
    input  logic                      enable,
    input  logic                      clear,
    input  logic                      writeEn,
    input  logic [BLOCK_WIDTH-1:0]    writeIdx,
    input  logic [7:0]                byteIn,
    output logic [BLOCK_SIZE*8-1:0]   lineNext
);

    logic [BLOCK_SIZE*8-1:0] line;

    // Merge the incoming byte so the final byte is visible at the completing edge.
    always_comb begin
        lineNext = line;
        if (writeEn) begin
            lineNext[8*writeIdx +: 8] = byteIn;
        end
    end

    always_ff @(posedge clockIn or negedge resetIn) begin
        if (!resetIn) begin
            line <= '0;
        end else if (enable) begin
            if (clear) begin
                line <= '0;
            end else begin
                line <= lineNext;
            end
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: arbitrates the I-cache refill port and the load/store port onto
// an 8-bit memory bus, sequencing multi-byte requests one byte per cycle.
// Optional feature macro: MEM_ARBITER_IO_STALL_EN (stall IO writes while the
// UART buffer is full; when undefined ioBufferFull is ignored).
// Ports: clockIn, resetIn (async active-low), readyIn (global enable),
// clearIn (flush of instruction transactions), memIn/memOut/memAddr/readWriteOut
// (byte bus), ioBufferFull, instrReq*/instrData* (line refill port),
// dataReq*/dataResp* (data port). Ready pulses and bus outputs are decoded
// from current state; response pulses and data are registered.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned BLOCK_WIDTH = 4,
    parameter int unsigned BLOCK_SIZE  = 16
) (
    input  logic                     clockIn,
    input  logic                     resetIn,
    input  logic                     readyIn,
    input  logic                     clearIn,
    input  logic [7:0]               memIn,
    output logic [7:0]               memOut,
    output logic [31:0]              memAddr,
    output logic                     readWriteOut,
    input  logic                     ioBufferFull,
    input  logic                     instrReqValid,
    input  logic [31:0]              instrReqAddr,
    output logic                     instrReqReady,
    output logic                     instrDataValid,
    output logic [BLOCK_SIZE*8-1:0]  instrData,
    input  logic                     dataReqValid,
    input  logic                     dataReqWrite,
    input  logic [1:0]               dataReqType,
    input  logic [31:0]              dataReqAddr,
    input  logic [31:0]              dataReqData,
    output logic                     dataReqReady,
    output logic                     dataRespValid,
    output logic [31:0]              dataResp
);

    localparam int unsigned CW = BLOCK_WIDTH + 1;
    localparam int unsigned LW = BLOCK_SIZE * 8;

    arbState       state, stateNext;
    logic [CW-1:0] cnt, cntNext, nBytes;
    grantSel       lastGrant;
    txnT           txn;
    logic          instrWant_c, grantInstr_c, grantData_c;
    logic          instrDone_c, dataDone_c, capture_c, ioStall_c;
    logic [LW-1:0] lineNext;

    // IO write stall on a full UART buffer.
`ifdef MEM_ARBITER_IO_STALL_EN
    assign ioStall_c = (txn.addr[17:16] == IO_REGION) && ioBufferFull;
`else
    logic unusedIoFull;
    assign unusedIoFull = ioBufferFull;
    assign ioStall_c    = 1'b0;
`endif

    // Fair arbitration: on a tie the requester not granted last wins.
    assign instrWant_c  = instrReqValid && !clearIn;
    assign grantData_c  = (state == IDLE) && dataReqValid
                          && (!instrWant_c || lastGrant == GRANT_INSTR);
    assign grantInstr_c = (state == IDLE) && instrWant_c
                          && (!dataReqValid || lastGrant == GRANT_DATA);
    assign instrReqReady = readyIn && grantInstr_c;
    assign dataReqReady  = readyIn && grantData_c;

    mem_byte_collector #(
        .BLOCK_WIDTH (BLOCK_WIDTH),
        .BLOCK_SIZE  (BLOCK_SIZE)
    ) u_collector (
        .clockIn  (clockIn),
        .resetIn  (resetIn),
        .enable   (readyIn),
        .clear    (grantInstr_c || grantData_c),
        .writeEn  (capture_c),
        .writeIdx (BLOCK_WIDTH'(cnt - CW'(1))),
        .byteIn   (memIn),
        .lineNext (lineNext)
    );

    // Next state, counter and bus drive.
    always_comb begin
        stateNext    = state;
        cntNext      = cnt;
        instrDone_c  = 1'b0;
        dataDone_c   = 1'b0;
        capture_c    = 1'b0;
        memAddr      = '0;
        memOut       = '0;
        readWriteOut = 1'b0;
        case (state)
            IDLE: begin
                cntNext = '0;
                if (grantData_c) begin
                    stateNext = dataReqWrite ? DWRITE : DREAD;
                end else if (grantInstr_c) begin
                    stateNext = IREAD;
                end
            end
            IREAD, DREAD: begin
                // Issue while cnt < N; the byte for address i arrives when cnt = i+1.
                if (cnt < nBytes) begin
                    memAddr = txn.addr + 32'(cnt);
                end
                capture_c = (cnt != '0);
                if (state == IREAD && clearIn) begin
                    stateNext = IDLE;
                end else if (cnt == nBytes) begin
                    stateNext = IDLE;
                    if (state == IREAD) begin
                        instrDone_c = 1'b1;
                    end else begin
                        dataDone_c = 1'b1;
                    end
                end else begin
                    cntNext = cnt + CW'(1);
                end
            end
            DWRITE: begin
                if (!ioStall_c) begin
                    memAddr      = txn.addr + 32'(cnt);
                    memOut       = txn.wrData[8*cnt[1:0] +: 8];
                    readWriteOut = 1'b1;
                    if (cnt == nBytes - CW'(1)) begin
                        stateNext  = IDLE;
                        dataDone_c = 1'b1;
                    end else begin
                        cntNext = cnt + CW'(1);
                    end
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clockIn or negedge resetIn) begin
        if (!resetIn) begin
            state <= IDLE;
            cnt   <= '0;
        end else if (readyIn) begin
            state <= stateNext;
            cnt   <= cntNext;
        end
    end

    // Request latch, grant history and registered responses.
    always_ff @(posedge clockIn or negedge resetIn) begin
        if (!resetIn) begin
            lastGrant      <= GRANT_INSTR;
            nBytes         <= '0;
            txn            <= '0;
            instrDataValid <= 1'b0;
            instrData      <= '0;
            dataRespValid  <= 1'b0;
            dataResp       <= '0;
        end else if (readyIn) begin
            instrDataValid <= instrDone_c;
            dataRespValid  <= dataDone_c;
            if (grantData_c) begin
                lastGrant  <= GRANT_DATA;
                nBytes     <= CW'(byteCount(dataReqType));
                txn.addr   <= dataReqAddr;
                txn.wrData <= dataReqData;
            end else if (grantInstr_c) begin
                lastGrant  <= GRANT_INSTR;
                nBytes     <= CW'(BLOCK_SIZE);
                txn.addr   <= instrReqAddr & ~32'(BLOCK_SIZE - 1);
                txn.wrData <= '0;
            end
            if (instrDone_c) begin
                instrData <= lineNext;
            end
            if (dataDone_c) begin
                dataResp <= (state == DWRITE) ? 32'h0 : lineNext[31:0];
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: scoreboard bench for mem_arbiter with a byte memory model.
module tb_mem_arbiter;

    localparam int unsigned BW = 4;
    localparam int unsigned BS = 16;
    localparam int unsigned LW = BS * 8;
`ifdef MEM_ARBITER_IO_STALL_EN
    localparam int IO_STALLS = 3;
`else
    localparam int IO_STALLS = 0;
`endif

    logic          clockIn;
    logic          resetIn, readyIn, clearIn, ioBufferFull;
    logic [7:0]    memIn = '0;
    logic [7:0]    memOut;
    logic [31:0]   memAddr;
    logic          readWriteOut;
    logic          instrReqValid, instrReqReady, instrDataValid;
    logic [31:0]   instrReqAddr;
    logic [LW-1:0] instrData;
    logic          dataReqValid, dataReqWrite, dataReqReady, dataRespValid;
    logic [1:0]    dataReqType;
    logic [31:0]   dataReqAddr, dataReqData, dataResp;

    typedef struct packed {logic [127:0] val; logic [31:0] cyc;} respT;
    typedef struct packed {logic [31:0] addr; logic [7:0] data; logic [31:0] cyc;} wrT;

    respT dataQ[$], instrQ[$];
    wrT   wrQ[$];
    respT dEnt, iEnt;
    wrT   wEnt;
    int   cyc = 0;
    int   nChecks = 0;
    int   nFails = 0;
    bit   wrMonOff = 0;

    mem_arbiter #(.BLOCK_WIDTH(BW), .BLOCK_SIZE(BS)) dut (
        .clockIn(clockIn), .resetIn(resetIn), .readyIn(readyIn), .clearIn(clearIn),
        .memIn(memIn), .memOut(memOut), .memAddr(memAddr), .readWriteOut(readWriteOut),
        .ioBufferFull(ioBufferFull),
        .instrReqValid(instrReqValid), .instrReqAddr(instrReqAddr),
        .instrReqReady(instrReqReady), .instrDataValid(instrDataValid), .instrData(instrData),
        .dataReqValid(dataReqValid), .dataReqWrite(dataReqWrite), .dataReqType(dataReqType),
        .dataReqAddr(dataReqAddr), .dataReqData(dataReqData), .dataReqReady(dataReqReady),
        .dataRespValid(dataRespValid), .dataResp(dataResp)
    );

    initial clockIn = 1'b0;
    always #5 clockIn = ~clockIn;

    task automatic checkVal(input string tag, input logic [127:0] got, input logic [127:0] expv);
        nChecks++;
        if (got !== expv) begin
            nFails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, expv, cyc);
        end
    endtask

    function automatic logic [7:0] memByte(input logic [31:0] a);
        case (a)
            32'h1000: return 8'h11;
            32'h1001: return 8'h22;
            32'h1002: return 8'h33;
            32'h1003: return 8'h44;
            default:  return a[7:0] ^ a[15:8] ^ a[31:24] ^ 8'h5A;
        endcase
    endfunction

    // Memory model: read data valid the cycle after its address, frozen with readyIn.
    always @(posedge clockIn) begin
        cyc <= cyc + 1;
        if (readyIn) memIn <= readWriteOut ? 8'h00 : memByte(memAddr);
    end

    always @(negedge clockIn) begin
        if (dataRespValid) begin
            if (dataQ.size() == 0) checkVal("dresp_unexpected", 128'(dataRespValid), 128'(0));
            else begin
                dEnt = dataQ.pop_front();
                checkVal("dresp_data", 128'(dataResp), dEnt.val);
                checkVal("dresp_cycle", 128'(cyc), 128'(dEnt.cyc));
            end
        end
        if (instrDataValid) begin
            if (instrQ.size() == 0) checkVal("iresp_unexpected", 128'(instrDataValid), 128'(0));
            else begin
                iEnt = instrQ.pop_front();
                checkVal("iresp_line", 128'(instrData), iEnt.val);
                checkVal("iresp_cycle", 128'(cyc), 128'(iEnt.cyc));
            end
        end
        if (readWriteOut && !wrMonOff) begin
            if (wrQ.size() == 0) checkVal("wr_unexpected", 128'(readWriteOut), 128'(0));
            else begin
                wEnt = wrQ.pop_front();
                checkVal("wr_addr", 128'(memAddr), 128'(wEnt.addr));
                checkVal("wr_data", 128'(memOut), 128'(wEnt.data));
                checkVal("wr_cycle", 128'(cyc), 128'(wEnt.cyc));
            end
        end
    end

    // Called at a negedge; returns at the negedge after acceptance.
    task automatic reqData(input bit wr, input logic [1:0] typ, input logic [31:0] addr,
                           input logic [31:0] data, input int extra, input bit track,
                           output int acc);
        int n;
        logic [31:0] expv;
        respT r;
        wrT w;
        n = (typ == 2'b00) ? 1 : (typ == 2'b01) ? 2 : 4;
        expv = '0;
        if (!wr) for (int i = 0; i < n; i++) expv[8*i +: 8] = memByte(addr + 32'(i));
        dataReqValid = 1'b1; dataReqWrite = wr; dataReqType = typ;
        dataReqAddr = addr;  dataReqData = data;
        acc = -1;
        for (int k = 0; k < 40; k++) begin
            #1;
            if (dataReqReady) begin acc = cyc; break; end
            @(negedge clockIn);
        end
        if (acc < 0) checkVal("dreq_accept_timeout", 128'(dataReqReady), 128'(1));
        else if (track) begin
            if (wr) for (int i = 0; i < n; i++) begin
                w.addr = addr + 32'(i); w.data = data[8*i +: 8]; w.cyc = 32'(acc + 1 + extra + i);
                wrQ.push_back(w);
            end
            r.val = 128'(expv);
            r.cyc = 32'(acc + n + (wr ? 1 : 2) + extra);
            dataQ.push_back(r);
        end
        @(negedge clockIn);
        dataReqValid = 1'b0;
    endtask

    task automatic reqInstr(input logic [31:0] addr, input bit track, output int acc);
        logic [LW-1:0] line;
        respT r;
        for (int i = 0; i < int'(BS); i++)
            line[8*i +: 8] = memByte((addr & ~32'(BS - 1)) + 32'(i));
        instrReqValid = 1'b1; instrReqAddr = addr;
        acc = -1;
        for (int k = 0; k < 40; k++) begin
            #1;
            if (instrReqReady) begin acc = cyc; break; end
            @(negedge clockIn);
        end
        if (acc < 0) checkVal("ireq_accept_timeout", 128'(instrReqReady), 128'(1));
        else if (track) begin
            r.val = 128'(line); r.cyc = 32'(acc + int'(BS) + 2);
            instrQ.push_back(r);
        end
        @(negedge clockIn);
        instrReqValid = 1'b0;
    endtask

    task automatic drain();
        for (int k = 0; k < 200; k++) begin
            if (dataQ.size() == 0 && instrQ.size() == 0 && wrQ.size() == 0) break;
            @(negedge clockIn);
        end
        repeat (3) @(negedge clockIn);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    initial begin
        int a0, a1;
        logic [1:0]  ldType [3] = '{2'b11, 2'b01, 2'b00};
        logic [31:0] ldAddr [3] = '{32'h1000, 32'hFFFF_FFFF, 32'h1003};

        resetIn = 1'b0; readyIn = 1'b1; clearIn = 1'b0; ioBufferFull = 1'b0;
        instrReqValid = 1'b0; instrReqAddr = '0;
        dataReqValid = 1'b0; dataReqWrite = 1'b0; dataReqType = '0;
        dataReqAddr = '0; dataReqData = '0;
        repeat (2) @(negedge clockIn);
        checkVal("rst_memAddr", 128'(memAddr), 128'(0));
        checkVal("rst_memOut", 128'(memOut), 128'(0));
        checkVal("rst_rw", 128'(readWriteOut), 128'(0));
        checkVal("rst_ivalid", 128'(instrDataValid), 128'(0));
        checkVal("rst_dvalid", 128'(dataRespValid), 128'(0));
        checkVal("rst_instrData", 128'(instrData), 128'(0));
        checkVal("rst_dataResp", 128'(dataResp), 128'(0));
        resetIn = 1'b1;
        @(negedge clockIn);

        // Tie from reset: data wins, instruction follows when IDLE again.
        fork
            reqData(1'b1, 2'b01, 32'h2002, 32'h0000_BEEF, 0, 1'b1, a0);
            reqInstr(32'h0, 1'b1, a1);
        join
        checkVal("tie_instr_accept_delay", 128'(a1 - a0), 128'(3));
        drain();

        // Word load with per-cycle address check.
        reqData(1'b0, 2'b10, 32'h1000, 32'h0, 0, 1'b1, a0);
        for (int i = 0; i < 4; i++) begin
            checkVal("wl_issue_addr", 128'(memAddr), 128'(32'h1000 + 32'(i)));
            checkVal("wl_issue_rw", 128'(readWriteOut), 128'(0));
            @(negedge clockIn);
        end
        checkVal("wl_drain_addr", 128'(memAddr), 128'(0));
        drain();

        // Reserved type as word, unaligned half across 32-bit wrap, single byte.
        for (int t = 0; t < 3; t++) begin
            reqData(1'b0, ldType[t], ldAddr[t], 32'h0, 0, 1'b1, a0);
            drain();
        end

        // Flush aborts a refill; next request accepted in the following cycle.
        reqInstr(32'h40, 1'b0, a0);
        repeat (4) @(negedge clockIn);
        clearIn = 1'b1;
        @(negedge clockIn);
        clearIn = 1'b0;
        checkVal("clr_idle_addr", 128'(memAddr), 128'(0));
        checkVal("clr_idle_rw", 128'(readWriteOut), 128'(0));
        reqInstr(32'h85, 1'b1, a1);
        checkVal("clr_reaccept_cycle", 128'(a1 - a0), 128'(6));
        drain();

        // readyIn low for two cycles mid word load.
        reqData(1'b0, 2'b10, 32'h1000, 32'h0, 2, 1'b1, a0);
        @(negedge clockIn);
        readyIn = 1'b0;
        repeat (2) @(negedge clockIn);
        readyIn = 1'b1;
        drain();

        // IO byte store with UART buffer full for three cycles.
        ioBufferFull = 1'b1;
        reqData(1'b1, 2'b00, 32'h0003_0000, 32'h41, IO_STALLS, 1'b1, a0);
        repeat (3) @(negedge clockIn);
        ioBufferFull = 1'b0;
        drain();

        // Asynchronous reset in the middle of a word store.
        wrMonOff = 1'b1;
        reqData(1'b1, 2'b10, 32'h5000, 32'hCAFE_F00D, 0, 1'b0, a0);
        @(negedge clockIn);
        resetIn = 1'b0;
        #1;
        checkVal("mid_rst_memAddr", 128'(memAddr), 128'(0));
        checkVal("mid_rst_memOut", 128'(memOut), 128'(0));
        checkVal("mid_rst_rw", 128'(readWriteOut), 128'(0));
        checkVal("mid_rst_instrData", 128'(instrData), 128'(0));
        checkVal("mid_rst_dvalid", 128'(dataRespValid), 128'(0));
        @(negedge clockIn);
        resetIn = 1'b1;
        wrMonOff = 1'b0;
        repeat (6) @(negedge clockIn);
        reqData(1'b0, 2'b00, 32'h1002, 32'h0, 0, 1'b1, a1);
        drain();

        checkVal("queues_empty", 128'(dataQ.size() + instrQ.size() + wrQ.size()), 128'(0));
        $display("[TB] %0d tests run, %0d failed", nChecks, nFails);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Byte-serial memory-bus arbiter and sequencer between the instruction-cache line refill port and the data (load/store) port. Sits between the cache front ends and the 8-bit external memory/IO bus. Converts multi-byte requests into per-byte address/data cycles, arbitrates fairly between the two requesters, stalls IO writes on a full UART buffer and honours pipeline flush.

## Interface
- BLOCK_WIDTH, 4: log2 of instruction line size in bytes.
- BLOCK_SIZE, 16: instruction line size in bytes; always 2**BLOCK_WIDTH.
- clockIn  in  1  system clock.
- resetIn  in  1  asynchronous, active-low reset.
- readyIn  in  1  global enable; low freezes all state.
- clearIn  in  1  misprediction flush; aborts instruction transactions only.
- memIn  in  8  memory read byte; valid the cycle after its address.
- memOut  out  8  memory write byte.
- memAddr  out  32  memory address.
- readWriteOut  out  1  1 = write, 0 = read.
- ioBufferFull  in  1  UART transmit buffer full.
- instrReqValid  in  1  line refill request; held until accepted.
- instrReqAddr  in  32  line address; low BLOCK_WIDTH bits ignored and treated as zero.
- instrReqReady  out  1  one-cycle accept pulse.
- instrDataValid  out  1  one-cycle line-ready pulse.
- instrData  out  BLOCK_SIZE*8  line; byte 0 in bits [7:0].
- dataReqValid  in  1  data request; held until accepted.
- dataReqWrite  in  1  1 = store.
- dataReqType  in  2  00 byte, 01 half, 10 word; 11 is treated as word.
- dataReqAddr  in  32  byte address; no alignment requirement.
- dataReqData  in  32  store data; low bytes used.
- dataReqReady  out  1  one-cycle accept pulse.
- dataRespValid  out  1  one-cycle pulse on load data ready or store done.
- dataResp  out  32  load data, little-endian, zero-extended. Sign extension is the requester's job. Zero for stores.

## Operation
- States: IDLE, IREAD, DREAD, DWRITE.
- IDLE arbitration:
  - One requester valid: grant it.
  - Both valid: grant the one not granted last (lastGrant bit).
  - lastGrant resets to instruction, so data wins the first tie.
  - instrReqValid is ignored in any cycle where clearIn is high.
- Grant:
  - The matching Ready output is asserted combinationally in the IDLE cycle.
  - At the clock edge: latch request, counter := 0, go to IREAD / DREAD / DWRITE.
- Byte count N: instruction = BLOCK_SIZE; data = 1 / 2 / 4 by type.
- Address for byte i = base + i, 32-bit wrap.
- Read states (IREAD, DREAD):
  - Issue cycles: drive memAddr = base+i with readWriteOut = 0, for i = 0..N-1.
  - Capture: each cycle after an issue cycle, memIn is stored as byte i.
  - Drain: one cycle with no issue (memAddr = 0) to capture the final byte.
  - Then: response pulse registered, return to IDLE.
- DWRITE:
  - Each cycle drive memAddr = base+i, memOut = data byte i, readWriteOut = 1.
  - After byte N-1: response pulse registered, return to IDLE.
- IO write stall:
  - Condition: latched address [17:16] == 2'b11 and ioBufferFull high.
  - The write cycle is suppressed: readWriteOut = 0, memAddr = 0, counter holds. Retry every cycle.
- clearIn high at an edge in IREAD: go to IDLE, no instrDataValid, partial line discarded.
- Data transactions are never aborted, including IO reads. The response still pulses; the requester discards it if stale.
- Idle bus: memAddr = 0, memOut = 0, readWriteOut = 0.

## Timing
- Reset (async, resetIn low):
  - State IDLE, counter 0, lastGrant = instruction.
  - All outputs 0, including instrData and dataResp.
- readyIn low: no register updates, outputs hold. Accept pulses are gated by readyIn.
- Read of N bytes, accepted in cycle 0:
  - Issue cycles: 1..N.
  - Captures: cycles 2..N+1.
  - Response pulse: cycle N+2; block is IDLE in that cycle and may accept a new request.
  - Word load: response in cycle 6. Line refill with BLOCK_SIZE 16: instrDataValid in cycle 18.
- Write of N bytes, accepted in cycle 0:
  - Bus writes: cycles 1..N.
  - dataRespValid: cycle N+1. Each IO stall cycle adds one cycle.
- The response data register holds its value until the next response.
- clearIn in the same cycle as an instrDataValid pulse does not cancel that pulse; the requester filters it.

## Configuration
- MEM_ARBITER_IO_STALL_EN defined: IO write stall active as described.
- MEM_ARBITER_IO_STALL_EN undefined: ioBufferFull is ignored and IO writes never stall. This is for simulation-only builds.

## Structure
- Shared package mem_arbiter_pkg holds:
  - the access-type encoding (byte / half / word);
  - the state encoding;
  - the IO region constant 2'b11 at bits [17:16];
  - IO addresses 0x30000 and 0x30004.
- One natural sub-module: mem_byte_collector.
  - A shift/assemble register of BLOCK_SIZE bytes with a write-index input.
  - Shared by IREAD and DREAD; dataResp uses its low 4 bytes.

## Test plan
- Word load at 0x1000, memory bytes 11 22 33 44 → addresses 0x1000–0x1003 in cycles 1–4; dataResp = 0x44332211 pulsed in cycle 6.
- Simultaneous instruction (0x0) and data (half store 0xBEEF to 0x2002) requests from reset → data granted first (writes EF, BE in cycles 1–2); instruction refill issued from cycle 4; instrDataValid in cycle 21.
- Line refill at 0x0040 with clearIn pulsed in cycle 5 → refill aborted, no instrDataValid, bus idle in cycle 6, new request accepted in cycle 6.
- Byte store 0x41 to 0x30000 with ioBufferFull high for 3 cycles → write held 3 cycles, then memOut = 0x41, readWriteOut = 1; response pulse 1 cycle later. With the macro undefined → no stall.
- readyIn low for 2 cycles mid word load → latency extends by exactly 2 cycles, result unchanged.
- resetIn low mid DWRITE → all outputs 0 immediately, no response; first request after release takes normal latency.
